// File: rtl/shifter_pipe.sv
// Pipelined log barrel shifter (SLL/SRA/ROR/SRL) with carry/zero flags,
// sideband tag and per-stage valid/ready flow control.
module shifter_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned TAG_W     = 4,
    localparam int unsigned SH_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned L = (SH_W + REG_EVERY - 1) / REG_EVERY;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SH_W-1:0]  shamt;
        logic [1:0]       mode;
        logic             sign;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // One mux level: shift d by amt using the operation's mode.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input int unsigned      amt,
                                                     input logic [1:0]       mode,
                                                     input logic             sign);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        case (mode)
            MODE_SLL: r = d << amt;
            MODE_SRA: r = (d >> amt) | (sign ? ~(ones >> amt) : '0);
            MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
            default:  r = d >> amt;
        endcase
        return r;
    endfunction

    // Carry is the last bit leaving the word; it depends only on the original operand.
    function automatic logic calc_carry(input logic [WIDTH-1:0] d,
                                        input logic [SH_W-1:0]  sh,
                                        input logic [1:0]       mode);
        logic [WIDTH-1:0] t;
        t = '0;
        if (sh != '0) begin
            if (mode == MODE_SLL) t = d >> (WIDTH - 32'(sh));
            else                  t = d >> (32'(sh) - 1);
        end
        return t[0];
    endfunction

    logic [L-1:0] vld;
    stage_t       st [L];
    logic [L-1:0] take;

    // Stage s may load when empty or when its content moves on downstream.
    always_comb begin
        take = '0;
        take[L-1] = !vld[L-1] || out_ready;
        for (int s = int'(L) - 2; s >= 0; s--) begin
            take[s] = !vld[s] || take[s+1];
        end
    end

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int TOP = int'(SH_W) - 1 - s * int'(REG_EVERY);

        stage_t src;
        stage_t nxt;
        stage_t q;
        logic   src_v;
        logic   v_q;

        if (s == 0) begin : g_first
            // Capture the operand, its sign and the final carry at entry.
            always_comb begin
                src       = '0;
                src.data  = in_data;
                src.shamt = in_shamt;
                src.mode  = in_mode;
                src.sign  = in_data[WIDTH-1];
                src.carry = calc_carry(in_data, in_shamt, in_mode);
                src.tag   = in_tag;
            end
            assign src_v = in_valid;
        end else begin : g_next
            assign src   = st[s-1];
            assign src_v = vld[s-1];
        end

        // Apply this stage's group of mux levels, highest shift first.
        always_comb begin
            nxt = src;
            for (int j = 0; j < int'(REG_EVERY); j++) begin
                if (j <= TOP) begin
                    if (((src.shamt >> (TOP - j)) & SH_W'(1)) != '0) begin
                        nxt.data = shift_level(nxt.data, 32'd1 << (TOP - j), src.mode, src.sign);
                    end
                end
            end
        end

        // Stage register: load on take, hold otherwise; payload only updates on a valid load.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                q   <= '0;
            end else if (take[s]) begin
                v_q <= src_v;
                if (src_v) q <= nxt;
            end
        end

        assign vld[s] = v_q;
        assign st[s]  = q;
    end

    assign in_ready  = take[0];
    assign out_valid = vld[L-1];
    assign out_data  = st[L-1].data;
    assign out_carry = st[L-1].carry;
    assign out_tag   = st[L-1].tag;
    assign out_zero  = (out_data == '0);

endmodule
